// File: rtl/fetch_control.sv
// Instruction-fetch sequencer: owns the fetch PC, drives the instruction memory address,
// buffers returned words in a 2-entry FIFO and hands them to decode over valid/ready.
module fetch_control #(
    parameter int unsigned                  BITS        = 32,
    parameter int unsigned                  i_addr_bits = 6,
    parameter logic [i_addr_bits-1:0]       RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   halt,
    input  logic                   redirect_valid,
    input  logic [i_addr_bits-1:0] redirect_pc,
    output logic [i_addr_bits-3:0] imem_addr,
    input  logic [BITS-1:0]        imem_dout,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [BITS-1:0]        instr,
    output logic [i_addr_bits-1:0] instr_pc,
    output logic                   running,
    output logic [1:0]             buf_count
);

    localparam int unsigned AW = i_addr_bits;
    localparam logic [AW-1:0] ALIGN_MASK = ~AW'(3);
    localparam logic [AW-1:0] START_PC   = RESET_PC & ALIGN_MASK;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_e;

    typedef struct packed {
        logic [BITS-1:0] word;
        logic [AW-1:0]   pc;
    } entry_t;

    state_e          state_q, state_d;
    logic [AW-1:0]   fetch_pc_q, fetch_pc_d;
    entry_t          ent0_q, ent0_d;
    entry_t          ent1_q, ent1_d;
    logic [1:0]      count_q, count_d;
    logic            pop, push;
    logic [1:0]      after_pop;
    entry_t          new_ent;

    // Shift FIFO: ent0 is the head and keeps the last-popped entry once the buffer drains.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        ent0_d     = ent0_q;
        ent1_d     = ent1_q;
        pop        = (count_q != 2'd0) && instr_ready;
        after_pop  = count_q - 2'(pop);
        push       = (state_q == S_RUN) && !redirect_valid && !halt && (after_pop < 2'd2);
        new_ent    = '{word: imem_dout, pc: fetch_pc_q};
        count_d    = after_pop + 2'(push);

        if (pop && (count_q == 2'd2) && !redirect_valid) begin
            ent0_d = ent1_q;
        end
        if (push) begin
            if (after_pop == 2'd0) begin
                ent0_d = new_ent;
            end else begin
                ent1_d = new_ent;
            end
            fetch_pc_d = fetch_pc_q + AW'(4);
        end

        // Redirect outranks halt and start in every state and flushes the buffer.
        if (redirect_valid) begin
            state_d    = S_RUN;
            fetch_pc_d = redirect_pc & ALIGN_MASK;
            count_d    = 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d    = S_RUN;
                        fetch_pc_d = START_PC;
                    end
                end
                S_RUN: begin
                    if (halt) begin
                        state_d = S_HALT;
                    end
                end
                S_HALT: begin
                    if (!halt && start) begin
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= START_PC;
            ent0_q     <= '0;
            ent1_q     <= '0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            count_q    <= count_d;
        end
    end

    assign imem_addr   = fetch_pc_q[AW-1:2];
    assign instr_valid = (count_q != 2'd0);
    assign instr       = ent0_q.word;
    assign instr_pc    = ent0_q.pc;
    assign running     = (state_q == S_RUN);
    assign buf_count   = count_q;

endmodule

// File: tb/tb_fetch_control.sv
// Scoreboard bench for fetch_control: directed scenarios queue expected instructions,
// a negedge monitor pops and compares on every completed handshake.
module tb_fetch_control;

    logic        clk = 1'b0;
    logic        rst, start, halt, redirect_valid, instr_ready;
    logic [5:0]  redirect_pc;
    logic [3:0]  imem_addr;
    logic [31:0] imem_dout;
    logic        instr_valid, running;
    logic [31:0] instr;
    logic [5:0]  instr_pc;
    logic [1:0]  buf_count;

    typedef struct {
        logic [31:0] word;
        logic [5:0]  pc;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    fetch_control #(.BITS(32), .i_addr_bits(6), .RESET_PC(6'd0)) dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_dout(imem_dout),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc),
        .running(running), .buf_count(buf_count)
    );

    always #5 clk = ~clk;

    // Memory word i holds 0xA000_0000 + i.
    assign imem_dout = 32'hA000_0000 + 32'(imem_addr);

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_word(input int w);
        exp_t e;
        e.word = 32'hA000_0000 + 32'(w);
        e.pc   = 6'((w * 4) % 64);
        sbq.push_back(e);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid"},   32'(instr_valid), 32'd0);
        check({tag, "_instr"},   instr,            32'd0);
        check({tag, "_pc"},      32'(instr_pc),    32'd0);
        check({tag, "_running"}, 32'(running),     32'd0);
        check({tag, "_count"},   32'(buf_count),   32'd0);
        check({tag, "_addr"},    32'(imem_addr),   32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_reset(tag);
    endtask

    // Monitor: every completed handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pop: got pc %h instr %h want none", instr_pc, instr);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("pop_instr", instr, e.word);
                check("pop_pc", 32'(instr_pc), 32'(e.pc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 6'd0; instr_ready = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        check_reset("reset");

        // Steady stream with instr_ready held high.
        instr_ready = 1'b1; start = 1'b1;
        for (int i = 0; i < 6; i++) expect_word(i);
        cyc(); start = 1'b0;
        check("start_running", 32'(running), 32'd1);
        check("start_addr", 32'(imem_addr), 32'd0);
        check("start_valid_n1", 32'(instr_valid), 32'd0);
        cyc();
        check("start_valid_n2", 32'(instr_valid), 32'd1);
        repeat (5) cyc();
        cyc(); instr_ready = 1'b0;
        do_reset("rst_a");

        // Backpressure: fill, then drain with no bubble.
        start = 1'b1;
        cyc(); start = 1'b0;
        repeat (4) cyc();
        check("bp_count", 32'(buf_count), 32'd2);
        check("bp_addr", 32'(imem_addr), 32'd2);
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) expect_word(i);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("bp_stream_valid", 32'(instr_valid), 32'd1);
            check("bp_stream_count", 32'(buf_count), 32'd2);
        end
        cyc(); instr_ready = 1'b0;
        check("full_count", 32'(buf_count), 32'd2);
        check("full_running", 32'(running), 32'd1);
        do_reset("rst_full");
        start = 1'b1; instr_ready = 1'b1;
        expect_word(0);
        cyc(); start = 1'b0;
        check("refetch_addr", 32'(imem_addr), 32'd0);
        cyc();
        check("refetch_pc", 32'(instr_pc), 32'd0);
        cyc(); instr_ready = 1'b0;
        do_reset("rst_b");

        // Redirect with pc 8 and 12 buffered, then misaligned target, then wrap.
        start = 1'b1;
        cyc(); start = 1'b0;
        cyc(); cyc();
        check("rd_fill_count", 32'(buf_count), 32'd2);
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) expect_word(i);
        cyc(); cyc();
        check("rd_head_pc", 32'(instr_pc), 32'h08);
        check("rd_head_count", 32'(buf_count), 32'd2);
        redirect_valid = 1'b1; redirect_pc = 6'h24;
        expect_word(9);
        cyc(); redirect_valid = 1'b0;
        check("rd_bubble_valid", 32'(instr_valid), 32'd0);
        check("rd_bubble_addr", 32'(imem_addr), 32'd9);
        expect_word(10);
        cyc();
        check("rd_target_instr", instr, 32'hA000_0009);
        cyc();
        redirect_valid = 1'b1; redirect_pc = 6'h27;
        expect_word(9);
        cyc(); redirect_valid = 1'b0;
        check("rd27_valid", 32'(instr_valid), 32'd0);
        check("rd27_addr", 32'(imem_addr), 32'd9);
        cyc();
        check("rd27_pc", 32'(instr_pc), 32'h24);
        redirect_valid = 1'b1; redirect_pc = 6'h3C;
        expect_word(15); expect_word(0); expect_word(1);
        cyc(); redirect_valid = 1'b0;
        check("wrap_addr", 32'(imem_addr), 32'd15);
        cyc(); cyc();
        check("wrap_pc", 32'(instr_pc), 32'h00);
        cyc();
        cyc(); instr_ready = 1'b0;
        do_reset("rst_c");

        // Halt with two buffered entries, drain, resume, then halt+redirect together.
        start = 1'b1;
        cyc(); start = 1'b0;
        cyc(); cyc();
        for (int i = 0; i < 3; i++) expect_word(i);
        instr_ready = 1'b1;
        cyc(); halt = 1'b1; instr_ready = 1'b0;
        cyc(); halt = 1'b0;
        check("halt_running", 32'(running), 32'd0);
        check("halt_count", 32'(buf_count), 32'd2);
        check("halt_addr", 32'(imem_addr), 32'd3);
        instr_ready = 1'b1;
        cyc(); cyc();
        check("halt_drained_valid", 32'(instr_valid), 32'd0);
        check("halt_drained_count", 32'(buf_count), 32'd0);
        cyc();
        check("halt_idle_valid", 32'(instr_valid), 32'd0);
        check("halt_hold_addr", 32'(imem_addr), 32'd3);
        expect_word(3); expect_word(4);
        start = 1'b1;
        cyc(); start = 1'b0;
        check("resume_running", 32'(running), 32'd1);
        check("resume_valid", 32'(instr_valid), 32'd0);
        cyc(); cyc();
        halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 6'h30;
        expect_word(12);
        cyc(); halt = 1'b0; redirect_valid = 1'b0;
        check("hr_running", 32'(running), 32'd1);
        check("hr_valid", 32'(instr_valid), 32'd0);
        check("hr_addr", 32'(imem_addr), 32'd12);
        cyc();
        cyc(); instr_ready = 1'b0;
        cyc();

        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
